// File: rtl/accel_pkg.sv
// accel_pkg: shared types and sizing constants for the accelerator control path.
package accel_pkg;
  localparam int VECTOR_DEPTH = 16;
  localparam int VECTOR_WIDTH = 16;
  localparam int MATRIX_DEPTH = 16;
  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_LOAD    = 3'd1,
    OP_STORE   = 3'd2,
    OP_COMPUTE = 3'd3
  } op_code_e;
  typedef enum logic [2:0] {
    COMP_ADD  = 3'd0,
    COMP_MUL  = 3'd1,
    COMP_TANH = 3'd2,
    COMP_RELU = 3'd3
  } comp_type_e;
  // Raw fields stay plain vectors so reserved encodings are representable.
  typedef struct packed {
    logic       valid;
    logic [2:0] op_code;
    logic [2:0] comp_type;
    logic [3:0] addr;
    logic       parity;
  } ctrl_packet_t;
  typedef struct packed {
    op_code_e   op_code;
    comp_type_e comp_type;
    logic [3:0] addr;
    logic       mem_access;
    logic       writes_output;
  } decoded_ctrl_t;
  function automatic logic parity_ok(ctrl_packet_t pkt);
    return pkt.parity == ^pkt[11:1];
  endfunction
endpackage

// File: rtl/ctrl_packet_checker.sv
// ctrl_packet_checker: combinational error detection and next-value decode of a control packet.
module ctrl_packet_checker
  import accel_pkg::*;
#(
  parameter bit CHECK_PARITY = 1'b1
) (
  input  ctrl_packet_t  pkt,
  output logic          perr,
  output logic          ierr,
  output decoded_ctrl_t dec
);
  logic is_comp;
  always_comb begin
    is_comp = pkt.op_code == OP_COMPUTE;
    perr = CHECK_PARITY && !parity_ok(pkt);
    ierr = pkt.op_code[2] || (is_comp && pkt.comp_type[2]);
    dec.op_code = op_code_e'(pkt.op_code);
    dec.comp_type = is_comp ? comp_type_e'(pkt.comp_type) : COMP_ADD;
    dec.addr = pkt.addr;
    dec.mem_access = pkt.op_code == OP_LOAD || pkt.op_code == OP_STORE;
    dec.writes_output = pkt.op_code == OP_LOAD || is_comp;
  end
endmodule

// File: rtl/ctrl_decoder.sv
// ctrl_decoder: registered decode of raw control packets into a held control record,
// with a one-cycle accept pulse and per-packet error status.
module ctrl_decoder
  import accel_pkg::*;
#(
  parameter bit CHECK_PARITY = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  ctrl_packet_t  ctrl_packet,
  output decoded_ctrl_t decoded_ctrl,
  output logic          decode_valid,
  output logic [1:0]    error_status
);
  logic perr, ierr, accept;
  decoded_ctrl_t dec;
  ctrl_packet_checker #(.CHECK_PARITY(CHECK_PARITY)) u_checker (
    .pkt (ctrl_packet),
    .perr(perr),
    .ierr(ierr),
    .dec (dec)
  );
  always_comb accept = ctrl_packet.valid && !perr && !ierr && ctrl_packet.op_code != OP_NOP;
  // decoded_ctrl only moves on an accepted packet; downstream relies on it holding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decoded_ctrl <= '0;
      decode_valid <= 1'b0;
      error_status <= 2'b00;
    end else begin
      decode_valid <= accept;
      error_status <= ctrl_packet.valid ? {perr, ierr} : 2'b00;
      if (accept) decoded_ctrl <= dec;
    end
  end
endmodule

// File: tb/tb_ctrl_decoder.sv
// tb_ctrl_decoder: directed table, corner sequences and random packets for ctrl_decoder
// with parity checking both enabled and disabled.
module tb_ctrl_decoder;
  import accel_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ctrl_packet_t ctrl_packet = '0;
  decoded_ctrl_t dc0, dc1;
  logic dv0, dv1;
  logic [1:0] es0, es1;
  int checks = 0;
  int errors = 0;
  int m_op[2], m_ct[2], m_addr[2], m_mem[2], m_wr[2], m_v[2], m_e[2];

  ctrl_decoder dut (
    .clk(clk), .rst_n(rst_n), .ctrl_packet(ctrl_packet),
    .decoded_ctrl(dc0), .decode_valid(dv0), .error_status(es0)
  );
  ctrl_decoder #(.CHECK_PARITY(1'b0)) dut_np (
    .clk(clk), .rst_n(rst_n), .ctrl_packet(ctrl_packet),
    .decoded_ctrl(dc1), .decode_valid(dv1), .error_status(es1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pkt;
    logic        v;
    logic [1:0]  e;
    logic [11:0] dec;
    logic        np_v;
    logic [1:0]  np_e;
  } vec_t;

  function automatic logic [11:0] flat(decoded_ctrl_t d);
    return {3'(d.op_code), 3'(d.comp_type), d.addr, d.mem_access, d.writes_output};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_op[i] = 0; m_ct[i] = 0; m_addr[i] = 0; m_mem[i] = 0; m_wr[i] = 0; m_v[i] = 0; m_e[i] = 0;
    end
  endtask

  // Reference: field extraction and rule evaluation with integer arithmetic.
  task automatic model(input logic [11:0] p);
    int valid, op, ct, addr, par, ones, perr, ierr;
    valid = (p >> 11) & 1;
    op = (p >> 8) & 7;
    ct = (p >> 5) & 7;
    addr = (p >> 1) & 15;
    par = p & 1;
    ones = $countones(p >> 1);
    for (int i = 0; i < 2; i++) begin
      perr = (i == 0 && par != ones % 2) ? 1 : 0;
      ierr = (op >= 4 || (op == 3 && ct >= 4)) ? 1 : 0;
      if (valid == 0) begin
        m_v[i] = 0; m_e[i] = 0;
      end else begin
        m_e[i] = perr * 2 + ierr;
        m_v[i] = (m_e[i] == 0 && op != 0) ? 1 : 0;
        if (m_v[i] == 1) begin
          m_op[i] = op;
          m_ct[i] = (op == 3) ? ct : 0;
          m_addr[i] = addr;
          m_mem[i] = (op == 1 || op == 2) ? 1 : 0;
          m_wr[i] = (op == 1 || op == 3) ? 1 : 0;
        end
      end
    end
  endtask

  task automatic chk_model(input string name);
    logic [11:0] e0, e1;
    e0 = {3'(m_op[0]), 3'(m_ct[0]), 4'(m_addr[0]), 1'(m_mem[0]), 1'(m_wr[0])};
    e1 = {3'(m_op[1]), 3'(m_ct[1]), 4'(m_addr[1]), 1'(m_mem[1]), 1'(m_wr[1])};
    chk({name, " valid"}, 12'(dv0), 12'(m_v[0]));
    chk({name, " err"}, 12'(es0), 12'(m_e[0]));
    chk({name, " dec"}, flat(dc0), e0);
    chk({name, " np_valid"}, 12'(dv1), 12'(m_v[1]));
    chk({name, " np_err"}, 12'(es1), 12'(m_e[1]));
    chk({name, " np_dec"}, flat(dc1), e1);
  endtask

  task automatic step(input logic [11:0] p);
    ctrl_packet = p;
    @(posedge clk);
    model(p);
    #1;
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{12'h90A, 1'b1, 2'b00, {3'd1, 3'd0, 4'd5, 1'b1, 1'b1}, 1'b1, 2'b00};
    tbl[1] = '{12'h000, 1'b0, 2'b00, {3'd1, 3'd0, 4'd5, 1'b1, 1'b1}, 1'b0, 2'b00};
    tbl[2] = '{12'hB26, 1'b1, 2'b00, {3'd3, 3'd1, 4'd3, 1'b0, 1'b1}, 1'b1, 2'b00};
    tbl[3] = '{12'hD01, 1'b0, 2'b01, {3'd3, 3'd1, 4'd3, 1'b0, 1'b1}, 1'b0, 2'b01};
    tbl[4] = '{12'hB80, 1'b0, 2'b01, {3'd3, 3'd1, 4'd3, 1'b0, 1'b1}, 1'b0, 2'b01};
    tbl[5] = '{12'h90B, 1'b0, 2'b10, {3'd3, 3'd1, 4'd3, 1'b0, 1'b1}, 1'b1, 2'b00};
    tbl[6] = '{12'h801, 1'b0, 2'b00, {3'd3, 3'd1, 4'd3, 1'b0, 1'b1}, 1'b0, 2'b00};
    tbl[7] = '{12'hA44, 1'b1, 2'b00, {3'd2, 3'd0, 4'd2, 1'b1, 1'b0}, 1'b1, 2'b00};
    tbl[8] = '{12'hD00, 1'b0, 2'b11, {3'd2, 3'd0, 4'd2, 1'b1, 1'b0}, 1'b0, 2'b01};

    ctrl_packet = 12'h90A;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset valid", 12'(dv0), 12'd0);
    chk("reset err", 12'(es0), 12'd0);
    chk("reset op", 12'(dc0.op_code), 12'(OP_NOP));
    chk("reset addr", 12'(dc0.addr), 12'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].pkt);
      chk($sformatf("tbl%0d valid", i), 12'(dv0), 12'(tbl[i].v));
      chk($sformatf("tbl%0d err", i), 12'(es0), 12'(tbl[i].e));
      chk($sformatf("tbl%0d dec", i), flat(dc0), tbl[i].dec);
      chk($sformatf("tbl%0d np_valid", i), 12'(dv1), 12'(tbl[i].np_v));
      chk($sformatf("tbl%0d np_err", i), 12'(es1), 12'(tbl[i].np_e));
      chk_model($sformatf("tbl%0d model", i));
    end

    for (int i = 0; i < 3; i++) begin
      step(12'hB26);
      chk($sformatf("held valid %0d", i), 12'(dv0), 12'd1);
    end

    step(12'h90A);
    chk("pre-async valid", 12'(dv0), 12'd1);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("async valid", 12'(dv0), 12'd0);
    chk("async dec", flat(dc0), 12'h000);
    chk("async np dec", flat(dc1), 12'h000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      logic [11:0] p;
      p = 12'($urandom);
      if ($urandom_range(0, 3) != 0) p[0] = ^p[11:1];
      if ($urandom_range(0, 1) != 0) p[10] = 1'b0;
      step(p);
      chk_model($sformatf("rnd%0d pkt=%h", n, p));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
